inst_queue: RTL and testbench

Parametrised instruction queue between the IF stage and the ID stage. It generalises the fixed two-instruction IF/ID pair register, including its one-instruction "left over" handling, into a circular buffer. The buffer accepts up to FETCH_WIDTH words per cycle from the instruction bus and presents up to ISSUE_WIDTH in-order instructions to the decoders. The ID-stage issue logic then consumes 0..ISSUE_WIDTH of them per cycle, so single-issue, dual-issue and wider-issue cycles all use the same path.

---
 rtl/inst_queue.sv | 124 ++++++++++++
 tb/tb_inst_queue.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// inst_queue: circular buffer between IF and ID; up to FETCH_WIDTH words in, up to ISSUE_WIDTH out per cycle.
// Define INST_QUEUE_BYPASS_EN to forward the accepted fetch beat straight to the issue slots in the same cycle.
module inst_queue #(
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             push_valid,
    output logic                             push_ready,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0] push_count,
    input  logic [31:0]                      push_pc,
    input  logic [32*FETCH_WIDTH-1:0]        push_inst,
    input  logic                             push_fault,
    output logic [ISSUE_WIDTH-1:0]           pop_valid,
    output logic [32*ISSUE_WIDTH-1:0]        pop_inst,
    output logic [32*ISSUE_WIDTH-1:0]        pop_pc,
    output logic [ISSUE_WIDTH-1:0]           pop_fault,
    input  logic [$clog2(ISSUE_WIDTH+1)-1:0] pop_count,
    output logic [$clog2(DEPTH+1)-1:0]       occupancy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic push_fire;
    int   occ;
    int   push_n;
    int   avail;
    int   pop_n;
    int   byp_n;

    function automatic entry_t beat_entry(input int j);
        entry_t e;
        e.inst  = push_inst[32*j +: 32];
        e.pc    = push_pc + 32'(4 * j);
        e.fault = push_fault;
        return e;
    endfunction

    // Readiness looks at stored occupancy only, so pop_count never reaches push_ready.
    always_comb begin
        occ        = int'(occupancy);
        push_ready = (occ <= DEPTH - FETCH_WIDTH);
        push_fire  = push_valid && push_ready && !flush;
        push_n     = 0;
        if (push_fire) begin
            push_n = (int'(push_count) > FETCH_WIDTH) ? FETCH_WIDTH : int'(push_count);
        end
`ifdef INST_QUEUE_BYPASS_EN
        avail = (occ + push_n > ISSUE_WIDTH) ? ISSUE_WIDTH : occ + push_n;
`else
        avail = (occ > ISSUE_WIDTH) ? ISSUE_WIDTH : occ;
`endif
        pop_n = (int'(pop_count) > avail) ? avail : int'(pop_count);
        // Beat words consumed in the same cycle never land in storage.
        byp_n = (pop_n > occ) ? pop_n - occ : 0;
    end

    always_comb begin
        entry_t slot;
        // NOTE: every output gets a default before the loop so no path leaves a latch behind.
        slot      = '0;
        pop_valid = '0;
        pop_inst  = '0;
        pop_pc    = '0;
        pop_fault = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            slot = '0;
            if (i < avail) begin
`ifdef INST_QUEUE_BYPASS_EN
                if (i < occ) slot = mem[head + PTR_W'(i)];
                else         slot = beat_entry(i - occ);
`else
                slot = mem[head + PTR_W'(i)];
`endif
                pop_valid[i] = 1'b1;
            end
            pop_inst[32*i +: 32] = slot.inst;
            pop_pc[32*i +: 32]   = slot.pc;
            pop_fault[i]         = slot.fault;
        end
    end

    // NOTE: storage is not reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            for (int j = 0; j < FETCH_WIDTH; j++) begin
                if (j >= byp_n && j < push_n) begin
                    mem[tail + PTR_W'(j - byp_n)] <= beat_entry(j);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            head      <= head + PTR_W'(pop_n - byp_n);
            tail      <= tail + PTR_W'(push_n - byp_n);
            occupancy <= occupancy + OCC_W'(push_n) - OCC_W'(pop_n);
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed scenarios plus randomized traffic against a queue-based FIFO model.
`timescale 1ns/1ps
module tb_inst_queue;
    localparam int FW    = 2;
    localparam int IW    = 2;
    localparam int DEPTH = 8;
    localparam int FCW   = $clog2(FW+1);
    localparam int ICW   = $clog2(IW+1);
    localparam int OCW   = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              push_valid;
    logic              push_ready;
    logic [FCW-1:0]    push_count;
    logic [31:0]       push_pc;
    logic [32*FW-1:0]  push_inst;
    logic              push_fault;
    logic [IW-1:0]     pop_valid;
    logic [32*IW-1:0]  pop_inst;
    logic [32*IW-1:0]  pop_pc;
    logic [IW-1:0]     pop_fault;
    logic [ICW-1:0]    pop_count;
    logic [OCW-1:0]    occupancy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } ent_t;

    ent_t mq[$];

    inst_queue #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push_valid(push_valid), .push_ready(push_ready), .push_count(push_count),
        .push_pc(push_pc), .push_inst(push_inst), .push_fault(push_fault),
        .pop_valid(pop_valid), .pop_inst(pop_inst), .pop_pc(pop_pc), .pop_fault(pop_fault),
        .pop_count(pop_count), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic int model_n();
        if (!(push_valid && !flush && mq.size() <= DEPTH - FW)) return 0;
        return (int'(push_count) > FW) ? FW : int'(push_count);
    endfunction

    function automatic ent_t beat(input int j);
        ent_t e;
        e.inst  = push_inst[32*j +: 32];
        e.pc    = push_pc + 32'(4 * j);
        e.fault = push_fault;
        return e;
    endfunction

    function automatic int model_avail();
        int v = mq.size();
`ifdef INST_QUEUE_BYPASS_EN
        v += model_n();
`endif
        return (v > IW) ? IW : v;
    endfunction

    function automatic ent_t model_slot(input int i);
        if (i >= model_avail()) return '0;
        if (i < mq.size()) return mq[i];
        return beat(i - mq.size());
    endfunction

    task automatic drive(input logic pv, input int cnt, input logic [31:0] pc,
                         input logic [32*FW-1:0] insts, input logic flt, input int pcnt, input logic fl);
        push_valid = pv;
        push_count = FCW'(cnt);
        push_pc    = pc;
        push_inst  = insts;
        push_fault = flt;
        pop_count  = ICW'(pcnt);
        flush      = fl;
    endtask

    // Advance one clock edge and apply the FIFO rules to the model.
    task automatic tick();
        int   n  = model_n();
        int   a  = model_avail();
        int   p  = (int'(pop_count) > a) ? a : int'(pop_count);
        logic fl = flush;
        ent_t b[$];
        for (int j = 0; j < n; j++) b.push_back(beat(j));
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            foreach (b[j]) mq.push_back(b[j]);
            repeat (p) void'(mq.pop_front());
        end
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(0, 0, 32'h0, '0, 0, 0, 0);
        #3;
        checks++; if (occupancy !== '0) begin failures++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        checks++; if (pop_valid !== '0) begin failures++; $display("FAIL reset_pop_valid: got %b want 0", pop_valid); end
        checks++; if (push_ready !== 1'b1) begin failures++; $display("FAIL reset_push_ready: got %b want 1", push_ready); end
        checks++; if (pop_inst !== '0 || pop_pc !== '0 || pop_fault !== '0) begin
            failures++; $display("FAIL reset_pop_data: got inst=%h pc=%h fault=%b want 0", pop_inst, pop_pc, pop_fault);
        end
        @(negedge clk);
        rst = 1'b1;
        mq.delete();
    endtask

    task automatic test_first_push();
        drive(1, 2, 32'hBFC0_0000, {32'h2402_0002, 32'h2401_0001}, 0, 0, 0);
        tick();
        drive(0, 0, 32'h0, '0, 0, 0, 0);
        #1;
        checks++; if (pop_valid !== 2'b11) begin failures++; $display("FAIL first_pop_valid: got %b want 11", pop_valid); end
        checks++; if (pop_pc !== {32'hBFC0_0004, 32'hBFC0_0000}) begin
            failures++; $display("FAIL first_pop_pc: got %h want bfc00004bfc00000", pop_pc);
        end
        checks++; if (pop_inst !== {32'h2402_0002, 32'h2401_0001}) begin
            failures++; $display("FAIL first_pop_inst: got %h want 2402000224010001", pop_inst);
        end
        checks++; if (occupancy !== 4'd2) begin failures++; $display("FAIL first_occ: got %0d want 2", occupancy); end
    endtask

    task automatic test_single_issue();
        drive(0, 0, 32'h0, '0, 0, 1, 0);
        #1;
        checks++; if (pop_inst[31:0] !== 32'h2401_0001) begin
            failures++; $display("FAIL single_slot0_a: got %h want 24010001", pop_inst[31:0]);
        end
        tick();
        #1;
        checks++; if (pop_inst[31:0] !== 32'h2402_0002 || pop_pc[31:0] !== 32'hBFC0_0004) begin
            failures++; $display("FAIL single_leftover: got inst=%h pc=%h want 24020002/bfc00004", pop_inst[31:0], pop_pc[31:0]);
        end
        checks++; if (pop_valid !== 2'b01 || pop_inst[63:32] !== 32'h0) begin
            failures++; $display("FAIL single_slot1_empty: got valid=%b inst1=%h want 01/0", pop_valid, pop_inst[63:32]);
        end
        tick();
        drive(0, 0, 32'h0, '0, 0, 0, 0);
        #1;
        checks++; if (pop_valid !== '0 || occupancy !== '0 || pop_pc !== '0) begin
            failures++; $display("FAIL single_drained: got valid=%b occ=%0d pc=%h want 0", pop_valid, occupancy, pop_pc);
        end
    endtask

    task automatic test_fill_wrap();
        for (int k = 0; k < 4; k++) begin
            drive(1, 2, 32'h1000 + 32'(8 * k), {32'h101 + 32'(2 * k), 32'h100 + 32'(2 * k)}, 0, 0, 0);
            tick();
            if (k == 2) begin
                checks++; if (occupancy !== 4'd6 || push_ready !== 1'b1) begin
                    failures++; $display("FAIL fill_at6: got occ=%0d ready=%b want 6/1", occupancy, push_ready);
                end
            end
        end
        checks++; if (occupancy !== 4'd8 || push_ready !== 1'b0) begin
            failures++; $display("FAIL fill_full: got occ=%0d ready=%b want 8/0", occupancy, push_ready);
        end
        // Full: this beat must be refused while the pop still goes through.
        drive(1, 2, 32'h2000, {32'h201, 32'h200}, 0, 2, 0);
        #1;
        checks++; if (pop_inst !== {32'h101, 32'h100}) begin
            failures++; $display("FAIL fill_full_pop: got %h want 0000010100000100", pop_inst);
        end
        tick();
        drive(1, 2, 32'h1020, {32'h109, 32'h108}, 0, 2, 0);
        #1;
        checks++; if (occupancy !== 4'd6 || push_ready !== 1'b1 || pop_inst !== {32'h103, 32'h102}) begin
            failures++; $display("FAIL fill_rejected: got occ=%0d ready=%b inst=%h want 6/1/0000010300000102", occupancy, push_ready, pop_inst);
        end
        tick();
        checks++; if (occupancy !== 4'd6) begin failures++; $display("FAIL fill_push_pop_occ: got %0d want 6", occupancy); end
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 32'h0, '0, 0, 2, 0);
            #1;
            checks++; if (pop_inst !== {32'h105 + 32'(2 * k), 32'h104 + 32'(2 * k)} ||
                          pop_pc !== {32'h1014 + 32'(8 * k), 32'h1010 + 32'(8 * k)}) begin
                failures++; $display("FAIL wrap_order_%0d: got inst=%h pc=%h", k, pop_inst, pop_pc);
            end
            tick();
        end
        checks++; if (occupancy !== '0) begin failures++; $display("FAIL wrap_drained: got %0d want 0", occupancy); end
    endtask

    task automatic test_flush();
        drive(1, 2, 32'h5000, {32'hA1, 32'hA0}, 0, 0, 0); tick();
        drive(1, 2, 32'h5008, {32'hA3, 32'hA2}, 0, 0, 0); tick();
        drive(1, 1, 32'h5010, {32'hA5, 32'hA4}, 0, 0, 0); tick();
        checks++; if (occupancy !== 4'd5) begin failures++; $display("FAIL flush_pre_occ: got %0d want 5", occupancy); end
        drive(1, 2, 32'h6000, {32'hB1, 32'hB0}, 0, 2, 1);
        tick();
        drive(0, 0, 32'h0, '0, 0, 0, 0);
        #1;
        checks++; if (occupancy !== '0 || pop_valid !== '0 || push_ready !== 1'b1) begin
            failures++; $display("FAIL flush_after: got occ=%0d valid=%b ready=%b want 0/00/1", occupancy, pop_valid, push_ready);
        end
    endtask

    task automatic test_fault();
        drive(1, 1, 32'h8000, {32'h1111_1111, 32'hDEAD_BEEF}, 1, 0, 0);
        tick();
        drive(0, 0, 32'h0, '0, 0, 0, 0);
        #1;
        checks++; if (pop_fault !== 2'b01 || pop_valid !== 2'b01 || pop_inst !== {32'h0, 32'hDEAD_BEEF}) begin
            failures++; $display("FAIL fault_slot: got fault=%b valid=%b inst=%h want 01/01/00000000deadbeef", pop_fault, pop_valid, pop_inst);
        end
        drive(0, 0, 32'h0, '0, 0, 2, 0);
        tick();
        drive(0, 0, 32'h0, '0, 0, 0, 0);
        #1;
        checks++; if (occupancy !== '0 || pop_valid !== '0) begin
            failures++; $display("FAIL fault_clamp: got occ=%0d valid=%b want 0/00", occupancy, pop_valid);
        end
        drive(1, 0, 32'h9000, {32'hC1, 32'hC0}, 0, 0, 0);
        tick();
        checks++; if (occupancy !== '0) begin failures++; $display("FAIL zero_count_noop: got %0d want 0", occupancy); end
    endtask

`ifdef INST_QUEUE_BYPASS_EN
    task automatic test_bypass();
        drive(1, 2, 32'h3000, {32'hE1, 32'hE0}, 0, 0, 0);
        #1;
        checks++; if (pop_valid !== 2'b11 || pop_pc[31:0] !== 32'h3000) begin
            failures++; $display("FAIL bypass_visible: got valid=%b pc0=%h want 11/3000", pop_valid, pop_pc[31:0]);
        end
        pop_count = ICW'(2);
        #1;
        tick();
        checks++; if (occupancy !== '0) begin failures++; $display("FAIL bypass_consumed: got %0d want 0", occupancy); end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic [IW-1:0]    ev;
            logic [IW-1:0]    ef;
            logic [32*IW-1:0] ei;
            logic [32*IW-1:0] ep;
            ent_t             s;
            push_valid = ($urandom % 5) != 0;
            push_count = FCW'($urandom % (1 << FCW));
            push_pc    = $urandom & 32'hFFFF_FFFC;
            for (int j = 0; j < FW; j++) push_inst[32*j +: 32] = $urandom;
            push_fault = ($urandom % 8) == 0;
            pop_count  = ($urandom % 2) ? ICW'($urandom % (1 << ICW)) : '0;
            flush      = ($urandom % 32) == 0;
            #1;
            ev = '0; ef = '0; ei = '0; ep = '0;
            for (int i = 0; i < IW; i++) begin
                s = model_slot(i);
                ev[i] = (i < model_avail());
                ei[32*i +: 32] = s.inst;
                ep[32*i +: 32] = s.pc;
                ef[i] = s.fault;
            end
            checks++; if (occupancy !== OCW'(mq.size())) begin
                failures++; $display("FAIL rand_occ[%0d]: got %0d want %0d", c, occupancy, mq.size());
            end
            checks++; if (push_ready !== (mq.size() <= DEPTH - FW)) begin
                failures++; $display("FAIL rand_ready[%0d]: got %b", c, push_ready);
            end
            checks++; if (pop_valid !== ev) begin failures++; $display("FAIL rand_valid[%0d]: got %b want %b", c, pop_valid, ev); end
            checks++; if (pop_inst !== ei) begin failures++; $display("FAIL rand_inst[%0d]: got %h want %h", c, pop_inst, ei); end
            checks++; if (pop_pc !== ep) begin failures++; $display("FAIL rand_pc[%0d]: got %h want %h", c, pop_pc, ep); end
            checks++; if (pop_fault !== ef) begin failures++; $display("FAIL rand_fault[%0d]: got %b want %b", c, pop_fault, ef); end
            tick();
        end
    endtask

    task automatic test_async_reset();
        drive(1, 2, 32'h7000, {32'hD1, 32'hD0}, 0, 0, 0); tick();
        drive(1, 2, 32'h7008, {32'hD3, 32'hD2}, 0, 0, 0); tick();
        drive(0, 0, 32'h0, '0, 0, 0, 0);
        #1;
        rst = 1'b0;
        #1;
        checks++; if (occupancy !== '0 || pop_valid !== '0 || push_ready !== 1'b1) begin
            failures++; $display("FAIL async_reset: got occ=%0d valid=%b ready=%b want 0/00/1", occupancy, pop_valid, push_ready);
        end
        mq.delete();
        drive(1, 2, 32'h4000, {32'hF1, 32'hF0}, 0, 0, 0);
        #1;
        rst = 1'b1;
        tick();
        drive(0, 0, 32'h0, '0, 0, 0, 0);
        #1;
        checks++; if (occupancy !== 4'd2 || pop_pc[31:0] !== 32'h4000) begin
            failures++; $display("FAIL post_reset_push: got occ=%0d pc0=%h want 2/4000", occupancy, pop_pc[31:0]);
        end
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_single_issue();
        test_fill_wrap();
        test_flush();
        test_fault();
`ifdef INST_QUEUE_BYPASS_EN
        test_bypass();
`endif
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
